// File: rtl/instr_fetch_if.sv
// Instruction memory read bus between instr_fetch and the instruction store.
//
// Signals:
//   mem_req    fetch -> mem  read request
//   mem_addr   fetch -> mem  word address (ADDR-1 bits)
//   mem_rdata  mem -> fetch  read data
//   mem_valid  mem -> fetch  mem_rdata is valid for the current mem_addr
//
// Modports: master (instr_fetch side), slave (memory side).
interface instr_fetch_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ADDR  = 16
);
  logic             mem_req;
  logic [ADDR-2:0]  mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_valid;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_valid
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit for a mixed short/long instruction stream.
//
// A memory word is either one long instruction (bit WIDTH-1 set) or a pair of
// short instructions (high half first, then low half). The unit fetches a word,
// then presents it to the decoder once (long) or twice (short pair), tracking a
// half-word program counter. A jump redirects to any half-word address.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             downstream hold; nothing is presented while high
//   jump_en/jump_addr one-cycle redirect to a half-word address
//   mem               instruction memory bus (instr_fetch_if.master)
//   dec_en            one-cycle decoder enable per presented instruction
//   long_instr        fetched word presented to the decoder
//   instr_choose      0 = high half, 1 = low half of a short pair
//   pc                half-word address of the presented instruction
//
// Configuration: define INSTR_PREFETCH_EN to add a one-word prefetch buffer
// that requests the next sequential word while the current one is issuing, so
// sequential words are handed over with no FETCH bubble.
module instr_fetch #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      ADDR     = 16,
  parameter logic [ADDR-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR-1:0]   jump_addr,
  instr_fetch_if.master     mem,
  output logic              dec_en,
  output logic [WIDTH-1:0]  long_instr,
  output logic              instr_choose,
  output logic [ADDR-1:0]   pc
);

  typedef enum logic [1:0] {
    StFetch,
    StIssueHi,
    StIssueLo,
    StIssueLong
  } state_e;

  localparam logic [ADDR-2:0] WordInc = {{(ADDR-2){1'b0}}, 1'b1};

  state_e           state_q;
  logic [ADDR-1:0]  pc_q;
  logic [WIDTH-1:0] instr_q;

  logic [ADDR-2:0]  word;
  logic [ADDR-2:0]  next_word;
  logic             leaving_word;
  logic             next_avail;
  logic [WIDTH-1:0] next_data;

  // Sequential word address wraps naturally in ADDR-1 bits.
  assign word      = pc_q[ADDR-1:1];
  assign next_word = word + WordInc;

  // Jump overrides any issue in the same cycle.
  assign dec_en       = (state_q != StFetch) && !stall && !jump_en;
  assign instr_choose = (state_q == StIssueLo);
  assign leaving_word = dec_en && ((state_q == StIssueLo) || (state_q == StIssueLong));

  assign long_instr = instr_q;
  assign pc         = pc_q;

  function automatic state_e entry_state(logic [WIDTH-1:0] w, logic half_lo);
    if (w[WIDTH-1]) begin
      return StIssueLong;
    end else if (half_lo) begin
      return StIssueLo;
    end
    return StIssueHi;
  endfunction

`ifdef INSTR_PREFETCH_EN
  logic             buf_valid_q;
  logic [WIDTH-1:0] buf_data_q;
  logic             pf_req;
  logic             pf_hit;

  // Keep requesting the next word while issuing until it is buffered.
  assign pf_req     = (state_q != StFetch) && !buf_valid_q;
  assign pf_hit     = pf_req && mem.mem_valid;
  // A response arriving in the hand-over cycle is forwarded directly.
  assign next_avail = buf_valid_q || pf_hit;
  assign next_data  = buf_valid_q ? buf_data_q : mem.mem_rdata;

  assign mem.mem_req  = rst_n && ((state_q == StFetch) || pf_req);
  assign mem.mem_addr = (state_q == StFetch) ? word : next_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
    end else if (jump_en || leaving_word) begin
      buf_valid_q <= 1'b0;
    end else if (pf_hit) begin
      buf_valid_q <= 1'b1;
      buf_data_q  <= mem.mem_rdata;
    end
  end
`else
  assign next_avail = 1'b0;
  assign next_data  = '0;

  assign mem.mem_req  = rst_n && (state_q == StFetch);
  assign mem.mem_addr = word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else if (jump_en) begin
      // Any response in this cycle belongs to the abandoned stream.
      state_q <= StFetch;
      pc_q    <= jump_addr;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (mem.mem_valid) begin
            instr_q <= mem.mem_rdata;
            state_q <= entry_state(mem.mem_rdata, pc_q[0]);
          end
        end
        StIssueHi: begin
          if (!stall) begin
            state_q <= StIssueLo;
            pc_q    <= {word, 1'b1};
          end
        end
        StIssueLo, StIssueLong: begin
          if (leaving_word) begin
            pc_q <= {next_word, 1'b0};
            if (next_avail) begin
              instr_q <= next_data;
              state_q <= entry_state(next_data, 1'b0);
            end else begin
              state_q <= StFetch;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
module tb_instr_fetch;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR   = 16;
  localparam int unsigned NWORDS = 1 << (ADDR - 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall = 1'b0;
  logic             jump_en = 1'b0;
  logic [ADDR-1:0]  jump_addr = '0;
  logic             dec_en;
  logic [WIDTH-1:0] long_instr;
  logic             instr_choose;
  logic [ADDR-1:0]  pc;

  int checks = 0;
  int failures = 0;

  instr_fetch_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

  instr_fetch #(.WIDTH(WIDTH), .ADDR(ADDR), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .mem          (bus),
    .dec_en       (dec_en),
    .long_instr   (long_instr),
    .instr_choose (instr_choose),
    .pc           (pc)
  );

  always #5 clk = ~clk;

  // Memory: answers the currently requested word after 0..max_lat extra cycles.
  logic [WIDTH-1:0] mem [NWORDS];
  logic             pend_q;
  logic [ADDR-2:0]  addr_q;
  int unsigned      cnt_q;
  int unsigned      max_lat = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      addr_q <= '0;
      cnt_q  <= 0;
    end else if (bus.mem_req && (!pend_q || addr_q != bus.mem_addr)) begin
      pend_q <= 1'b1;
      addr_q <= bus.mem_addr;
      cnt_q  <= $urandom_range(max_lat, 0);
    end else if (cnt_q != 0) begin
      cnt_q <= cnt_q - 1;
    end
  end

  assign bus.mem_valid = bus.mem_req && pend_q && (addr_q == bus.mem_addr) && (cnt_q == 0);
  assign bus.mem_rdata = bus.mem_valid ? mem[bus.mem_addr] : 32'hDEAD_BEEF;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 of the first cycle after reset release.
  task automatic do_reset(input int unsigned lat);
    max_lat = lat;
    stall = 1'b0;
    jump_en = 1'b0;
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_issue(input int unsigned budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dec_en) begin
        seen = 1'b1;
        return;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    mem[0] = 32'h8A05_1234;
    rst_n = 1'b0;
    max_lat = 0;
    #1;
    @(negedge clk);
    checks += 6;
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got %b want 0", bus.mem_req); end
    if (bus.mem_addr !== 15'h0) begin failures++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
    if (dec_en !== 1'b0) begin failures++; $display("FAIL rst_dec_en got %b want 0", dec_en); end
    if (long_instr !== 32'h0) begin failures++; $display("FAIL rst_long_instr got %h want 0", long_instr); end
    if (instr_choose !== 1'b0) begin failures++; $display("FAIL rst_choose got %b want 0", instr_choose); end
    if (pc !== 16'h0) begin failures++; $display("FAIL rst_pc got %h want 0", pc); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL rel_mem_req got %b want 1", bus.mem_req); end
  endtask

  task automatic test_long();
    mem[0] = 32'h8A05_1234;
    mem[1] = 32'h0123_4567;
    do_reset(0);
    @(negedge clk);
    checks++;
    if (dec_en !== 1'b0 || bus.mem_addr !== 15'h0) begin
      failures++; $display("FAIL long_fetch dec_en=%b addr=%h want 0/0", dec_en, bus.mem_addr);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks += 4;
    if (dec_en !== 1'b1) begin failures++; $display("FAIL long_dec got %b want 1", dec_en); end
    if (long_instr !== 32'h8A05_1234) begin
      failures++; $display("FAIL long_instr got %h want 8a051234", long_instr);
    end
    if (instr_choose !== 1'b0) begin failures++; $display("FAIL long_choose got %b want 0", instr_choose); end
    if (pc !== 16'h0000) begin failures++; $display("FAIL long_pc got %h want 0000", pc); end
    next_cycle();
    @(negedge clk);
    checks += 2;
    if (dec_en !== 1'b0) begin failures++; $display("FAIL long_once got %b want 0", dec_en); end
    if (bus.mem_addr !== 15'h0001) begin
      failures++; $display("FAIL long_next_addr got %h want 0001", bus.mem_addr);
    end
  endtask

  task automatic test_short_pair();
    mem[0] = 32'h4ABC_0123;
    mem[1] = 32'h8000_0001;
    do_reset(0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (dec_en !== 1'b1 || instr_choose !== 1'b0 || pc !== 16'h0000 || long_instr !== 32'h4ABC_0123) begin
      failures++;
      $display("FAIL pair_hi dec=%b ch=%b pc=%h ins=%h want 1/0/0000/4abc0123",
               dec_en, instr_choose, pc, long_instr);
    end
    checks++;
`ifdef INSTR_PREFETCH_EN
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 15'h0001) begin
      failures++; $display("FAIL pair_pf_req req=%b addr=%h want 1/0001", bus.mem_req, bus.mem_addr);
    end
`else
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL pair_issue_req got %b want 0", bus.mem_req); end
`endif
    next_cycle();
    @(negedge clk);
    checks++;
    if (dec_en !== 1'b1 || instr_choose !== 1'b1 || pc !== 16'h0001) begin
      failures++;
      $display("FAIL pair_lo dec=%b ch=%b pc=%h want 1/1/0001", dec_en, instr_choose, pc);
    end
    next_cycle();
    @(negedge clk);
    checks++;
`ifdef INSTR_PREFETCH_EN
    if (dec_en !== 1'b1 || pc !== 16'h0002 || long_instr !== 32'h8000_0001) begin
      failures++; $display("FAIL pair_pf_next dec=%b pc=%h ins=%h want 1/0002/80000001",
                           dec_en, pc, long_instr);
    end
`else
    if (dec_en !== 1'b0 || bus.mem_addr !== 15'h0001 || bus.mem_req !== 1'b1) begin
      failures++; $display("FAIL pair_refetch dec=%b addr=%h req=%b want 0/0001/1",
                           dec_en, bus.mem_addr, bus.mem_req);
    end
`endif
  endtask

  task automatic test_stall();
    mem[0] = 32'h1234_5678;
    do_reset(0);
    next_cycle();
    next_cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dec_en !== 1'b0 || pc !== 16'h0000 || long_instr !== 32'h1234_5678) begin
        failures++; $display("FAIL stall_hold[%0d] dec=%b pc=%h ins=%h want 0/0000/12345678",
                             i, dec_en, pc, long_instr);
      end
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (dec_en !== 1'b1 || instr_choose !== 1'b0 || pc !== 16'h0000) begin
      failures++; $display("FAIL stall_hi dec=%b ch=%b pc=%h want 1/0/0000", dec_en, instr_choose, pc);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (dec_en !== 1'b1 || instr_choose !== 1'b1 || pc !== 16'h0001 || long_instr !== 32'h1234_5678) begin
      failures++; $display("FAIL stall_lo dec=%b ch=%b pc=%h ins=%h want 1/1/0001/12345678",
                           dec_en, instr_choose, pc, long_instr);
    end
  endtask

  task automatic test_jump();
    bit seen;
    mem[0] = 32'h0000_1111;
    mem[8] = 32'h2222_3333;
    mem[9] = 32'h8000_0009;
    do_reset(0);
    next_cycle();
    next_cycle();
    jump_en = 1'b1;
    jump_addr = 16'h0011;
    stall = 1'b1;
    @(negedge clk);
    checks++;
    if (dec_en !== 1'b0) begin failures++; $display("FAIL jump_cycle_dec got %b want 0", dec_en); end
    next_cycle();
    jump_en = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_addr !== 15'h0008 || dec_en !== 1'b0 || pc !== 16'h0011) begin
      failures++; $display("FAIL jump_fetch addr=%h dec=%b pc=%h want 0008/0/0011",
                           bus.mem_addr, dec_en, pc);
    end
    next_cycle();
    wait_issue(10, seen);
    checks++;
    if (!seen || instr_choose !== 1'b1 || pc !== 16'h0011 || long_instr !== 32'h2222_3333) begin
      failures++; $display("FAIL jump_lo seen=%b ch=%b pc=%h ins=%h want 1/1/0011/22223333",
                           seen, instr_choose, pc, long_instr);
    end
    next_cycle();
    wait_issue(10, seen);
    checks++;
    if (!seen || pc !== 16'h0012 || long_instr !== 32'h8000_0009 || instr_choose !== 1'b0) begin
      failures++; $display("FAIL jump_after seen=%b pc=%h ins=%h ch=%b want 1/0012/80000009/0",
                           seen, pc, long_instr, instr_choose);
    end
  endtask

  task automatic test_long_odd_jump();
    bit seen;
    mem[16] = 32'h9000_00AA;
    mem[17] = 32'h0555_0666;
    do_reset(0);
    jump_en = 1'b1;
    jump_addr = 16'h0021;
    next_cycle();
    jump_en = 1'b0;
    wait_issue(10, seen);
    checks++;
    if (!seen || pc !== 16'h0021 || instr_choose !== 1'b0 || long_instr !== 32'h9000_00AA) begin
      failures++; $display("FAIL oddlong seen=%b pc=%h ch=%b ins=%h want 1/0021/0/900000aa",
                           seen, pc, instr_choose, long_instr);
    end
    next_cycle();
    wait_issue(10, seen);
    checks++;
    if (!seen || pc !== 16'h0022 || long_instr !== 32'h0555_0666) begin
      failures++; $display("FAIL oddlong_next seen=%b pc=%h ins=%h want 1/0022/05550666",
                           seen, pc, long_instr);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    mem[NWORDS-1] = 32'h8765_4321;
    mem[0] = 32'h0BAD_F00D;
    do_reset(0);
    jump_en = 1'b1;
    jump_addr = 16'hFFFE;
    next_cycle();
    jump_en = 1'b0;
    wait_issue(10, seen);
    checks++;
    if (!seen || pc !== 16'hFFFE || long_instr !== 32'h8765_4321) begin
      failures++; $display("FAIL wrap_top seen=%b pc=%h ins=%h want 1/fffe/87654321", seen, pc, long_instr);
    end
`ifndef INSTR_PREFETCH_EN
    next_cycle();
    @(negedge clk);
`endif
    checks++;
    if (bus.mem_addr !== 15'h0000) begin
      failures++; $display("FAIL wrap_addr got %h want 0000", bus.mem_addr);
    end
    next_cycle();
    wait_issue(10, seen);
    checks++;
    if (!seen || pc !== 16'h0000 || long_instr !== 32'h0BAD_F00D || instr_choose !== 1'b0) begin
      failures++; $display("FAIL wrap_next seen=%b pc=%h ins=%h want 1/0000/0badf00d", seen, pc, long_instr);
    end
  endtask

  task automatic test_stream();
    bit seen;
    int ones;
    int req_in_issue;
    for (int i = 0; i < 8; i++) mem[i] = $urandom() & 32'h7FFF_FFFF;
    do_reset(0);
    wait_issue(10, seen);
    checks++;
    if (!seen) begin failures++; $display("FAIL stream_start got no issue want issue"); end
    ones = 0;
    req_in_issue = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        next_cycle();
        @(negedge clk);
      end
      if (dec_en) ones++;
      if (dec_en && bus.mem_req) req_in_issue++;
    end
    checks++;
`ifdef INSTR_PREFETCH_EN
    if (ones != 8) begin failures++; $display("FAIL stream_zero_bubble got %0d want 8", ones); end
`else
    if (ones >= 8) begin failures++; $display("FAIL stream_bubble got %0d want <8", ones); end
    checks++;
    if (req_in_issue != 0) begin
      failures++; $display("FAIL stream_issue_req got %0d want 0", req_in_issue);
    end
`endif
  endtask

  // Reference model: walks the instruction stream from the memory image.
  task automatic test_random();
    logic [ADDR-1:0]  mpc;
    logic [WIDTH-1:0] w;
    logic             exp_ch;
    bit               after_jump;
    int               idle;
    int               issues;
    do_reset(2);
    mpc = 16'h0000;
    after_jump = 1'b0;
    idle = 0;
    issues = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      stall = ($urandom_range(3, 0) == 0);
      jump_en = ($urandom_range(24, 0) == 0);
      jump_addr = 16'($urandom());
      @(negedge clk);
      if (jump_en) begin
        checks++;
        if (dec_en !== 1'b0) begin failures++; $display("FAIL rand_jump_dec got %b want 0", dec_en); end
        mpc = jump_addr;
        after_jump = 1'b1;
        idle = 0;
      end else begin
        if (dec_en) begin
          w = mem[mpc[ADDR-1:1]];
          exp_ch = !w[WIDTH-1] && mpc[0];
          checks++;
          if (after_jump || stall || pc !== mpc || long_instr !== w || instr_choose !== exp_ch) begin
            failures++;
            $display("FAIL rand_issue c=%0d pc=%h ins=%h ch=%b aj=%b st=%b want pc=%h ins=%h ch=%b",
                     cyc, pc, long_instr, instr_choose, after_jump, stall, mpc, w, exp_ch);
          end
          if (w[WIDTH-1] || mpc[0]) mpc = {mpc[ADDR-1:1] + 15'd1, 1'b0};
          else mpc = mpc + 16'd1;
          issues++;
          idle = 0;
        end else begin
          idle++;
        end
        after_jump = 1'b0;
      end
      if (idle > 40) begin
        checks++;
        failures++;
        $display("FAIL rand_progress idle=%0d want <=40", idle);
        break;
      end
      next_cycle();
    end
    stall = 1'b0;
    jump_en = 1'b0;
    checks++;
    if (issues < 200) begin failures++; $display("FAIL rand_issue_count got %0d want >=200", issues); end
  endtask

  initial begin
    for (int i = 0; i < int'(NWORDS); i++) mem[i] = $urandom();
    test_reset();
    test_long();
    test_short_pair();
    test_stall();
    test_jump();
    test_long_odd_jump();
    test_wrap();
    test_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, instruction word width; ADDR, default 16, half-word address width; RESET_PC, default 0, half-word start address.
REQ-002 clk  in  1  single clock; all state SHALL update on posedge (the decoder samples on negedge).
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 stall  in  1  downstream hold; no new instruction is presented while high.
REQ-005 jump_en  in  1  redirect request, one-cycle pulse.
REQ-006 jump_addr  in  ADDR  redirect target, half-word address: [ADDR-1:1] word, [0] half (0=high, 1=low).
REQ-007 mem_req  out  1  instruction memory read request.
REQ-008 mem_addr  out  ADDR-1  word address of the request.
REQ-009 mem_rdata  in  WIDTH  read data.
REQ-010 mem_valid  in  1  mem_rdata valid for the current mem_addr; ignored while mem_req=0.
REQ-011 dec_en  out  1  decoder enable, high for one cycle per presented instruction.
REQ-012 long_instr  out  WIDTH  fetched word presented to the decoder.
REQ-013 instr_choose  out  1  0=high half, 1=low half of a short pair.
REQ-014 pc  out  ADDR  half-word address of the instruction currently presented.

Function
REQ-015 States SHALL be FETCH, ISSUE_HI, ISSUE_LO, ISSUE_LONG.
REQ-016 In FETCH: mem_req=1, mem_addr=pc[ADDR-1:1], held stable until mem_valid; on mem_valid the word is latched into long_instr.
REQ-017 FETCH exit on mem_valid: rdata[WIDTH-1]=1 -> ISSUE_LONG; else pc[0]=0 -> ISSUE_HI; else -> ISSUE_LO.
REQ-018 ISSUE_x with stall=0: dec_en=1 for exactly that cycle; instr_choose=1 only in ISSUE_LO, 0 otherwise.
REQ-019 ISSUE_HI -> ISSUE_LO, pc+1; ISSUE_LO and ISSUE_LONG -> FETCH, pc advanced to the next word, pc[0]=0.
REQ-020 ISSUE_x with stall=1: dec_en=0; state, pc and long_instr held.
REQ-021 A long word reached via a jump with jump_addr[0]=1 SHALL still be issued once, as ISSUE_LONG.
REQ-022 jump_en SHALL take priority over stall and over every state: next cycle FETCH with pc=jump_addr, dec_en=0; a mem_valid in the jump cycle is discarded.
REQ-023 Sequential word address SHALL wrap modulo 2^(ADDR-1) without error.
REQ-024 dec_en SHALL never be high in FETCH or in the cycle following a jump.

Reset
REQ-025 While rst_n=0: state=FETCH, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC[ADDR-1:1], dec_en=0, long_instr=0, instr_choose=0.
REQ-026 In the first cycle after rst_n rises, mem_req SHALL be 1; a reset mid-fetch abandons the request and any late mem_valid is ignored.

Configuration
REQ-027 Macro INSTR_PREFETCH_EN SHALL control a one-word prefetch buffer.
REQ-028 With INSTR_PREFETCH_EN defined: during ISSUE states mem_req=1 for the next sequential word; the response is held in the buffer; on leaving the word, a valid buffer SHALL be consumed with no FETCH cycle (zero bubble); jump_en and reset clear the buffer.
REQ-029 Without INSTR_PREFETCH_EN: mem_req=0 in ISSUE states, and every word passes through FETCH (at least one bubble per word).

Verification
REQ-030 Reset release; mem_valid one cycle later with 0x8A05_1234 at word 0 -> one dec_en pulse, long_instr=0x8A051234, instr_choose=0, pc=0x0000; then mem_addr=0x0001.
REQ-031 Word 0 = 0x4ABC_0123 -> two dec_en pulses: instr_choose=0 with pc=0x0000, then instr_choose=1 with pc=0x0001; then FETCH at mem_addr=0x0001.
REQ-032 stall high 3 cycles in ISSUE_HI -> dec_en=0 for 3 cycles; then issues high and low halves of the same word.
REQ-033 jump_en=1, jump_addr=0x0011, stall=1 in the same cycle during ISSUE_HI -> next cycle mem_addr=0x0008; a short word returned -> only the low half issued (instr_choose=1, pc=0x0011).
REQ-034 Sequential word address 0x7FFF (ADDR=16) -> next fetch at mem_addr=0x0000.
REQ-035 INSTR_PREFETCH_EN defined, 1-cycle memory, four consecutive short pairs -> dec_en continuously high for 8 cycles after the first issue.
